// File: rtl/fifo_wr_arbiter.sv
// Burst round-robin arbiter sharing one async-FIFO write port among N_REQ requesters.
// Optional full-stall watchdog enabled by defining FIFO_WR_ARB_WATCHDOG_EN.
module fifo_wr_arbiter #(
   parameter int N_REQ       = 3,
   parameter int DATA_WIDTH  = 8,
   parameter int MAX_BEATS   = 4,
   parameter int STALL_LIMIT = 16
) (
   input  logic                          wr_clk,
   input  logic                          rst,
   input  logic [N_REQ-1:0]              req,
   input  logic [N_REQ*DATA_WIDTH-1:0]   din_flat,
   input  logic [N_REQ-1:0]              last,
   input  logic                          fifo_full,
   output logic [N_REQ-1:0]              grant,
   output logic [N_REQ-1:0]              ack,
   output logic                          fifo_wr_en,
   output logic [DATA_WIDTH-1:0]         fifo_din,
   output logic                          busy,
   output logic                          stall_err
);

   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int CNT_W = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
   localparam logic [CNT_W-1:0] CNT_CAP = CNT_W'(MAX_BEATS - 1);

   typedef enum logic {IDLE, BURST} state_t;

   state_t             state_q, state_d;
   logic [N_REQ-1:0]   grant_q, grant_d;
   logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;

   logic [IDX_W-1:0]   g_idx;
   logic [IDX_W-1:0]   win_idx;
   logic [IDX_W-1:0]   scan_idx;
   logic               win_found;
   logic               last_beat;

   assign grant      = grant_q;
   assign ack        = grant_q & req & {N_REQ{~fifo_full}};
   assign fifo_wr_en = |ack;
   assign busy       = (state_q == BURST);

   always_comb begin
      g_idx = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (grant_q[i]) g_idx = IDX_W'(i);
      end
   end

   always_comb begin
      fifo_din = '0;
      if (|grant_q) fifo_din = din_flat[int'(g_idx)*DATA_WIDTH +: DATA_WIDTH];
   end

   // Search starts one past the previous winner so the last holder has lowest priority.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      scan_idx  = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         scan_idx = IDX_W'((int'(rr_ptr_q) + k) % N_REQ);
         if (!win_found && req[scan_idx]) begin
            win_found = 1'b1;
            win_idx   = scan_idx;
         end
      end
   end

   assign last_beat = fifo_wr_en & (last[g_idx] | (beat_cnt_q == CNT_CAP));

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      rr_ptr_d   = rr_ptr_q;
      beat_cnt_d = beat_cnt_q;
      case (state_q)
         IDLE: begin
            if (win_found) begin
               grant_d          = '0;
               grant_d[win_idx] = 1'b1;
               beat_cnt_d       = '0;
               state_d          = BURST;
            end
         end
         BURST: begin
            if (last_beat) begin
               grant_d  = '0;
               rr_ptr_d = g_idx;
               state_d  = IDLE;
            end else if (fifo_wr_en) begin
               beat_cnt_d = beat_cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge wr_clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         grant_q    <= '0;
         rr_ptr_q   <= IDX_W'(N_REQ - 1);
         beat_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         rr_ptr_q   <= rr_ptr_d;
         beat_cnt_q <= beat_cnt_d;
      end
   end

`ifdef FIFO_WR_ARB_WATCHDOG_EN
   localparam int STALL_W = $clog2(STALL_LIMIT + 1);

   logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;
   logic               stall_err_q, stall_err_d;

   // Saturates at the limit; the error flag is sticky until reset.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      stall_err_d = stall_err_q;
      if (state_q != BURST || fifo_wr_en) begin
         stall_cnt_d = '0;
      end else if ((|(grant_q & req)) && fifo_full &&
                   (stall_cnt_q != STALL_W'(STALL_LIMIT))) begin
         stall_cnt_d = stall_cnt_q + 1'b1;
         if (stall_cnt_q == STALL_W'(STALL_LIMIT - 1)) stall_err_d = 1'b1;
      end
   end

   always_ff @(posedge wr_clk or posedge rst) begin
      if (rst) begin
         stall_cnt_q <= '0;
         stall_err_q <= 1'b0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         stall_err_q <= stall_err_d;
      end
   end

   assign stall_err = stall_err_q;
`else
   assign stall_err = 1'b0;
`endif

endmodule
